core_ifetch: RTL
================

# core_ifetch

Instruction fetch unit: consumes the PC produced by the PC generator, performs one instruction-bus read per PC, and presents the fetched instruction to decode. It drives the PC generator's hold input, so the PC advances only when the instruction for the current PC has been captured. On a jump or software reset it discards in-flight fetches. It sits between the PC generator and the decode stage, and is the only master on the instruction bus.

## Interface
Parameters:
- DW, `DATA_BUS_WIDTH (32): address, instruction and PC width
- NOP_INST, 32'h0000_0013: instruction value driven when the slot is empty or on a bus error

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous, active-low
- reset_flag_i  in  1  software reset; same pulse that goes to the PC generator
- flush_i  in  1  jump taken; same cycle as the PC generator's jump_flag_i
- pc_i  in  DW  current PC from the PC generator
- hold_o  out  1  to the PC generator's hold_flag_i; 0 only in the cycle the PC advances
- ibus_req_o  out  1  read request
- ibus_addr_o  out  DW  read address; equals pc_i
- ibus_gnt_i  in  1  request accepted this cycle
- ibus_rvalid_i  in  1  single-cycle response strobe
- ibus_rdata_i  in  DW  read data, valid with rvalid
- ibus_err_i  in  1  response error, valid with rvalid
- dec_ready_i  in  1  decode consumes the output slot this cycle
- inst_valid_o  out  1  output slot holds an instruction
- inst_o  out  DW  instruction
- inst_pc_o  out  DW  PC of inst_o
- inst_err_o  out  1  fetch bus error for inst_o

## Operation
- Bus rules:
  - At most one outstanding transaction.
  - ibus_addr_o is combinational from pc_i.
  - The request is held until gnt. It may be withdrawn or change address only while not granted.
  - The response arrives at least 1 cycle after gnt.
- FSM states: IDLE, REQ, WAIT, BUF, DISCARD. Reset state is IDLE.
- IDLE: moves to REQ the next cycle.
- REQ: ibus_req_o=1.
  - gnt: go to WAIT.
  - flush with gnt: go to DISCARD.
  - flush without gnt: stay in REQ and request the new pc_i next cycle.
- WAIT: waits for rvalid.
  - rvalid with the slot free (inst_valid_o=0 or dec_ready_i=1): load the slot ({rdata, pc_i, err}), drive hold_o=0 (advance), go to REQ.
  - rvalid with the slot busy: capture the response in the buffer, go to BUF.
- BUF: when the slot frees, move the buffer into the slot, drive hold_o=0, go to REQ.
- DISCARD: waits for rvalid, drops the response, goes to REQ.
- Flush (flush_i or reset_flag_i) in any state:
  - Clears inst_valid_o the next cycle.
  - Suppresses any advance in that cycle.
  - WAIT goes to DISCARD. If rvalid arrives in the same cycle, the response is dropped and the state goes to REQ.
  - BUF drops the buffer and goes to REQ.
- Error: when ibus_err_i is set, the slot is loaded with inst_o=NOP_INST and inst_err_o=1. It advances like a normal response.
- Slot consumption: dec_ready_i with inst_valid_o=1 and no advance clears inst_valid_o the next cycle.

## Timing
- Reset values: inst_valid_o=0, inst_o=NOP_INST, inst_pc_o=0, inst_err_o=0, state IDLE, so ibus_req_o=0 and hold_o=1.
- Best-case latency:
  - Cycle 0: req+gnt.
  - Cycle 1: rvalid, hold_o=0.
  - Cycle 2: inst_valid_o=1 and pc_i=PC+4.
  - Throughput is 1 instruction per 2 cycles (non-pipelined by design).
- hold_o is combinational; it is low in exactly one cycle per delivered instruction.
- Flush priority: flush_i/reset_flag_i beat rvalid and dec_ready_i. The PC generator's jump beats hold, so hold_o during a flush has no effect.
- reset_flag_i behaves as a flush; the FSM does not return to IDLE.

## Structure
- DW and RESET_PC_ADDR come from chip_param.v. Add NOP_INST and the FSM state encodings there.
- No sub-module. Buffer and slot registers live inline.

## Test plan
- Zero-wait bus, dec_ready=1, reset PC 0x0 -> inst_pc_o sequence 0x0, 0x4, 0x8, one every 2 cycles; hold_o low once per instruction.
- gnt delayed 3 cycles, rvalid 2 cycles after gnt -> ibus_addr_o stable at 0x4 until gnt; one transaction; slot loads 0x4.
- dec_ready=0 for 5 cycles with a response arriving -> FSM enters BUF; no second request; pc_i holds; the instruction is delivered in order when ready rises.
- flush_i in WAIT with jump target 0x100, rvalid 1 cycle later -> old data dropped; next request to 0x100; inst_pc_o=0x100.
- ibus_err_i on fetch of 0x8 -> inst_o=0x0000_0013, inst_err_o=1, PC advances to 0xC.
- rst_n_i asserted mid-WAIT -> all outputs at reset values immediately; fetch restarts at RESET_PC_ADDR after IDLE.

Source files
------------

// File: rtl/core_ifetch_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
// Bus width and reset PC mirror the chip-level parameters.
package core_ifetch_pkg;

  localparam int          DATA_BUS_WIDTH = 32;
  localparam logic [31:0] RESET_PC_ADDR  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INST   = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT    = 3'd2,
    S_BUF     = 3'd3,
    S_DISCARD = 3'd4
  } ifetch_state_e;

endpackage

// File: rtl/core_ifetch.sv
// Instruction fetch: one non-pipelined bus read per PC, a one-entry output
// slot towards decode, and a one-entry buffer for when decode stalls.
module core_ifetch
  import core_ifetch_pkg::*;
#(
  parameter int            DW       = DATA_BUS_WIDTH,
  parameter logic [DW-1:0] NOP_INST = DEF_NOP_INST
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          reset_flag_i,
  input  logic          flush_i,
  input  logic [DW-1:0] pc_i,
  output logic          hold_o,
  output logic          ibus_req_o,
  output logic [DW-1:0] ibus_addr_o,
  input  logic          ibus_gnt_i,
  input  logic          ibus_rvalid_i,
  input  logic [DW-1:0] ibus_rdata_i,
  input  logic          ibus_err_i,
  input  logic          dec_ready_i,
  output logic          inst_valid_o,
  output logic [DW-1:0] inst_o,
  output logic [DW-1:0] inst_pc_o,
  output logic          inst_err_o
);

  ifetch_state_e state;
  logic [DW-1:0] buf_inst;
  logic          buf_err;

  logic          flush;
  logic          slot_free;
  logic          advance;
  logic [DW-1:0] resp_inst;

  assign flush       = flush_i | reset_flag_i;
  assign slot_free   = ~inst_valid_o | dec_ready_i;
  assign resp_inst   = ibus_err_i ? NOP_INST : ibus_rdata_i;
  assign ibus_req_o  = (state == S_REQ);
  assign ibus_addr_o = pc_i;
  assign hold_o      = ~advance;

  // The PC may only move once the current PC's instruction lands in the slot;
  // a flush owns the PC generator that cycle, so no advance is signalled.
  always_comb begin
    advance = 1'b0;
    if (!flush) begin
      case (state)
        S_WAIT:  advance = ibus_rvalid_i & slot_free;
        S_BUF:   advance = slot_free;
        default: advance = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= S_IDLE;
      buf_inst     <= NOP_INST;
      buf_err      <= 1'b0;
      inst_valid_o <= 1'b0;
      inst_o       <= NOP_INST;
      inst_pc_o    <= '0;
      inst_err_o   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (ibus_gnt_i) begin
            state <= flush ? S_DISCARD : S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state <= ibus_rvalid_i ? S_REQ : S_DISCARD;
          end else if (ibus_rvalid_i) begin
            if (slot_free) begin
              state <= S_REQ;
            end else begin
              buf_inst <= resp_inst;
              buf_err  <= ibus_err_i;
              state    <= S_BUF;
            end
          end
        end
        S_BUF: begin
          if (flush || slot_free) begin
            state <= S_REQ;
          end
        end
        S_DISCARD: begin
          if (ibus_rvalid_i) begin
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase

      // pc_i is still held at the fetched PC when the slot is loaded.
      if (flush) begin
        inst_valid_o <= 1'b0;
      end else if (advance) begin
        inst_valid_o <= 1'b1;
        inst_pc_o    <= pc_i;
        if (state == S_BUF) begin
          inst_o     <= buf_inst;
          inst_err_o <= buf_err;
        end else begin
          inst_o     <= resp_inst;
          inst_err_o <= ibus_err_i;
        end
      end else if (dec_ready_i) begin
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule
